// File: rtl/wb_pkg.sv
// Shared encodings for the writeback unit.
// Source selects, load sizes and FSM states.
package wb_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2,
        SEL_NONE = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_WORDX = 2'd3
    } ld_size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load data alignment: picks the byte/half at the
// offset and zero- or sign-extends it.
module load_align #(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [OFF_W-1:0]  offset,
    output logic [DATA_W-1:0] result
);
    import wb_pkg::*;

    logic [OFF_W-1:0]  half_off;
    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;

    assign half_off = {offset[OFF_W-1:1], 1'b0};
    assign byte_sh  = data >> {offset, 3'b000};
    assign half_sh  = data >> {half_off, 3'b000};

    // Select and extend the addressed lane
    always_comb begin
        result = data;
        case (ld_size_e'(size))
            SZ_BYTE:
                result = {{(DATA_W-8){sign_ext & byte_sh[7]}},
                          byte_sh[7:0]};
            SZ_HALF:
                result = {{(DATA_W-16){sign_ext & half_sh[15]}},
                          half_sh[15:0]};
            default:
                result = data;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: routes ALU/LINK/MEM results to the
// register bank, waiting for memory with a timeout.
module writeback_unit #(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 5,
    parameter  int TIMEOUT = 15,
    localparam int OFF_W   = $clog2(DATA_W / 8)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [1:0]        WB_SEL,
    input  logic              RD_EN,
    input  logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic [DATA_W-1:0] LINK_VALUE,
    input  logic [1:0]        LD_SIZE,
    input  logic              LD_SIGNED,
    input  logic [OFF_W-1:0]  LD_OFFSET,
    input  logic              MEM_VALID,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              REG_WE,
    output logic [ADDR_W-1:0] REG_AA_ADDR,
    output logic [DATA_W-1:0] REG_AA_DATA,
    output logic              ERR
);
    import wb_pkg::*;

    wb_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic              l_rd_en;
    logic [ADDR_W-1:0] l_addr;
    logic [1:0]        l_size;
    logic              l_signed;
    logic [OFF_W-1:0]  l_off;
    logic [DATA_W-1:0] ld_data;

    assign IN_READY = (state == IDLE);

    load_align #(.DATA_W(DATA_W)) u_align (
        .data     (MEM_DATA),
        .size     (l_size),
        .sign_ext (l_signed),
        .offset   (l_off),
        .result   (ld_data)
    );

    // Request FSM, load latch, timeout and write port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            l_rd_en     <= 1'b0;
            l_addr      <= '0;
            l_size      <= '0;
            l_signed    <= 1'b0;
            l_off       <= '0;
            REG_WE      <= 1'b0;
            REG_AA_ADDR <= '0;
            REG_AA_DATA <= '0;
            ERR         <= 1'b0;
        end else begin
            REG_WE <= 1'b0;
            ERR    <= 1'b0;
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        case (wb_sel_e'(WB_SEL))
                            SEL_ALU, SEL_LINK: begin
                                if (RD_EN) begin
                                    REG_WE      <= (RD_ADDR != '0);
                                    REG_AA_ADDR <= RD_ADDR;
                                    REG_AA_DATA <=
                                        (WB_SEL == SEL_LINK) ?
                                        LINK_VALUE : ALU_RESULT;
                                end
                            end
                            SEL_MEM: begin
                                l_rd_en  <= RD_EN;
                                l_addr   <= RD_ADDR;
                                l_size   <= LD_SIZE;
                                l_signed <= LD_SIGNED;
                                l_off    <= LD_OFFSET;
                                cnt      <= '0;
                                state    <= WAIT_MEM;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_MEM: begin
                    if (MEM_VALID) begin
                        if (l_rd_en) begin
                            REG_WE      <= (l_addr != '0);
                            REG_AA_ADDR <= l_addr;
                            REG_AA_DATA <= ld_data;
                        end
                        state <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        ERR   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit.
// Vector table plus MEM, timeout and reset sequences.
module tb_writeback_unit;
    import wb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  WB_SEL;
    logic        RD_EN;
    logic [4:0]  RD_ADDR;
    logic [31:0] ALU_RESULT;
    logic [31:0] LINK_VALUE;
    logic [1:0]  LD_SIZE;
    logic        LD_SIGNED;
    logic [1:0]  LD_OFFSET;
    logic        MEM_VALID;
    logic [31:0] MEM_DATA;
    logic        REG_WE;
    logic [4:0]  REG_AA_ADDR;
    logic [31:0] REG_AA_DATA;
    logic        ERR;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] alu;
        logic [31:0] link;
        logic        we;
        logic [4:0]  eaddr;
        logic [31:0] edata;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t tbl[9];
    wr_t  sb[$];

    writeback_unit #(
        .DATA_W(32), .ADDR_W(5), .TIMEOUT(15)
    ) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .WB_SEL(WB_SEL), .RD_EN(RD_EN),
        .RD_ADDR(RD_ADDR), .ALU_RESULT(ALU_RESULT),
        .LINK_VALUE(LINK_VALUE), .LD_SIZE(LD_SIZE),
        .LD_SIGNED(LD_SIGNED), .LD_OFFSET(LD_OFFSET),
        .MEM_VALID(MEM_VALID), .MEM_DATA(MEM_DATA),
        .REG_WE(REG_WE), .REG_AA_ADDR(REG_AA_ADDR),
        .REG_AA_DATA(REG_AA_DATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the queue head
    always @(negedge CLK) begin
        if (REG_WE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_spurious_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_addr", 32'(REG_AA_ADDR), 32'(e.addr));
                chk("sb_data", REG_AA_DATA, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_vec(input vec_t v);
        IN_VALID   = v.v;
        WB_SEL     = v.sel;
        RD_EN      = v.en;
        RD_ADDR    = v.addr;
        ALU_RESULT = v.alu;
        LINK_VALUE = v.link;
        if (v.v && v.we) sb.push_back('{v.eaddr, v.edata});
    endtask

    task automatic idle_in();
        IN_VALID = 1'b0;
        WB_SEL   = SEL_NONE;
        RD_EN    = 1'b0;
        RD_ADDR  = 5'd0;
    endtask

    task automatic mem_load(input logic [1:0] sz,
                            input logic sg,
                            input logic [1:0] off,
                            input logic [4:0] addr,
                            input logic en,
                            input logic [31:0] d,
                            input int dly,
                            input logic ewe,
                            input logic [4:0] ea,
                            input logic [31:0] ed);
        IN_VALID  = 1'b1;
        WB_SEL    = SEL_MEM;
        RD_EN     = en;
        RD_ADDR   = addr;
        LD_SIZE   = sz;
        LD_SIGNED = sg;
        LD_OFFSET = off;
        MEM_VALID = 1'b1;
        MEM_DATA  = 32'h5A5A_5A5A;
        if (ewe) sb.push_back('{ea, ed});
        for (int k = 1; k <= dly; k++) begin
            @(negedge CLK);
            chk("mem_ready_low", 32'(IN_READY), 32'd0);
            IN_VALID  = (k < dly);
            WB_SEL    = SEL_ALU;
            RD_EN     = 1'b1;
            RD_ADDR   = 5'd9;
            LD_SIZE   = SZ_WORD;
            LD_SIGNED = ~sg;
            LD_OFFSET = 2'd0;
            MEM_VALID = (k == dly);
            MEM_DATA  = (k == dly) ? d : 32'hFFFF_FFFF;
        end
        @(negedge CLK);
        chk("mem_we", 32'(REG_WE), 32'(ewe));
        chk("mem_addr", 32'(REG_AA_ADDR), 32'(ea));
        chk("mem_data", REG_AA_DATA, ed);
        chk("mem_ready_back", 32'(IN_READY), 32'd1);
        chk("mem_no_err", 32'(ERR), 32'd0);
        MEM_VALID = 1'b0;
        idle_in();
    endtask

    initial begin
        int waits;
        logic early_err;

        tbl[0] = '{1, SEL_ALU,  1, 5'd7,  32'h0000_1234, 32'h0,
                   1, 5'd7,  32'h0000_1234};
        tbl[1] = '{1, SEL_LINK, 1, 5'd3,  32'h1111_1111, 32'h100,
                   1, 5'd3,  32'h0000_0100};
        tbl[2] = '{1, SEL_ALU,  0, 5'd9,  32'hDEAD_0000, 32'h0,
                   0, 5'd3,  32'h0000_0100};
        tbl[3] = '{1, SEL_NONE, 1, 5'd5,  32'h55,        32'h66,
                   0, 5'd3,  32'h0000_0100};
        tbl[4] = '{1, SEL_LINK, 1, 5'd0,  32'h0,         32'h40,
                   0, 5'd0,  32'h0000_0040};
        tbl[5] = '{1, SEL_ALU,  1, 5'd31, 32'hFFFF_FFFF, 32'h0,
                   1, 5'd31, 32'hFFFF_FFFF};
        tbl[6] = '{1, SEL_LINK, 1, 5'd1,  32'h999,  32'h8000_0004,
                   1, 5'd1,  32'h8000_0004};
        tbl[7] = '{0, SEL_ALU,  1, 5'd4,  32'h777,       32'h0,
                   0, 5'd1,  32'h8000_0004};
        tbl[8] = '{1, SEL_ALU,  1, 5'd4,  32'hA5A5_0001, 32'h0,
                   1, 5'd4,  32'hA5A5_0001};

        RST = 1'b1;
        idle_in();
        ALU_RESULT = '0;
        LINK_VALUE = '0;
        LD_SIZE    = '0;
        LD_SIGNED  = 1'b0;
        LD_OFFSET  = '0;
        MEM_VALID  = 1'b0;
        MEM_DATA   = '0;
        repeat (2) @(negedge CLK);
        chk("rst_we", 32'(REG_WE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_addr", 32'(REG_AA_ADDR), 32'd0);
        chk("rst_data", REG_AA_DATA, 32'd0);
        chk("rst_ready", 32'(IN_READY), 32'd1);
        RST = 1'b0;
        @(negedge CLK);

        MEM_VALID = 1'b1;
        MEM_DATA  = 32'hDEAD_BEEF;
        drive_vec(tbl[0]);
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            chk($sformatf("vec%0d_we", i),
                32'(REG_WE), 32'(tbl[i].we));
            chk($sformatf("vec%0d_addr", i),
                32'(REG_AA_ADDR), 32'(tbl[i].eaddr));
            chk($sformatf("vec%0d_data", i),
                REG_AA_DATA, tbl[i].edata);
            chk($sformatf("vec%0d_ready", i),
                32'(IN_READY), 32'd1);
            if (i < 8) drive_vec(tbl[i+1]);
            else idle_in();
        end
        MEM_VALID = 1'b0;
        @(negedge CLK);

        mem_load(SZ_BYTE,  1, 2'd2, 5'd10, 1, 32'h1280_FF00, 3,
                 1, 5'd10, 32'hFFFF_FF80);
        mem_load(SZ_HALF,  0, 2'd2, 5'd11, 1, 32'hBEEF_0000, 1,
                 1, 5'd11, 32'h0000_BEEF);
        mem_load(SZ_BYTE,  0, 2'd2, 5'd12, 1, 32'h1280_FF00, 2,
                 1, 5'd12, 32'h0000_0080);
        mem_load(SZ_HALF,  1, 2'd3, 5'd13, 1, 32'hBEEF_0000, 1,
                 1, 5'd13, 32'hFFFF_BEEF);
        mem_load(SZ_WORDX, 1, 2'd1, 5'd14, 1, 32'hCAFE_F00D, 2,
                 1, 5'd14, 32'hCAFE_F00D);
        mem_load(SZ_BYTE,  1, 2'd0, 5'd15, 1, 32'h0000_007F, 1,
                 1, 5'd15, 32'h0000_007F);
        mem_load(SZ_HALF,  0, 2'd0, 5'd0,  1, 32'h1234_5678, 2,
                 0, 5'd0,  32'h0000_5678);
        mem_load(SZ_BYTE,  1, 2'd1, 5'd20, 0, 32'hFFFF_FFFF, 1,
                 0, 5'd0,  32'h0000_5678);

        IN_VALID = 1'b1;
        WB_SEL   = SEL_MEM;
        RD_EN    = 1'b1;
        RD_ADDR  = 5'd22;
        waits     = 0;
        early_err = 1'b0;
        @(negedge CLK);
        idle_in();
        while (IN_READY !== 1'b1 && waits < 40) begin
            waits++;
            if (ERR !== 1'b0) early_err = 1'b1;
            @(negedge CLK);
        end
        chk("to_wait_cycles", 32'(waits), 32'd16);
        chk("to_early_err", 32'(early_err), 32'd0);
        chk("to_err_pulse", 32'(ERR), 32'd1);
        chk("to_no_we", 32'(REG_WE), 32'd0);
        chk("to_hold_addr", 32'(REG_AA_ADDR), 32'd0);
        chk("to_hold_data", REG_AA_DATA, 32'h0000_5678);
        @(negedge CLK);
        chk("to_err_one_cycle", 32'(ERR), 32'd0);

        drive_vec('{1, SEL_ALU, 1, 5'd6, 32'h77, 32'h0,
                    1, 5'd6, 32'h77});
        @(negedge CLK);
        chk("pre_rst_data", REG_AA_DATA, 32'h77);
        IN_VALID = 1'b1;
        WB_SEL   = SEL_MEM;
        RD_EN    = 1'b1;
        RD_ADDR  = 5'd21;
        LD_SIZE  = SZ_WORD;
        @(negedge CLK);
        idle_in();
        repeat (2) @(negedge CLK);
        chk("pre_rst_waiting", 32'(IN_READY), 32'd0);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_we", 32'(REG_WE), 32'd0);
        chk("async_rst_addr", 32'(REG_AA_ADDR), 32'd0);
        chk("async_rst_data", REG_AA_DATA, 32'd0);
        chk("async_rst_ready", 32'(IN_READY), 32'd1);
        @(negedge CLK);
        RST       = 1'b0;
        MEM_VALID = 1'b1;
        MEM_DATA  = 32'h1111_1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("post_rst_we", 32'(REG_WE), 32'd0);
            chk("post_rst_err", 32'(ERR), 32'd0);
            chk("post_rst_data", REG_AA_DATA, 32'd0);
        end
        MEM_VALID = 1'b0;
        @(negedge CLK);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_W, default 32, register data width; SHALL be a multiple of 8 and at least 32.
REQ-002 Parameter ADDR_W, default 5, register index width.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles waited for a memory response (1..255).
REQ-004 Derived OFF_W = log2(DATA_W/8), byte-offset width.
REQ-005 Ports SHALL be, in this order:
 CLK  in  1  single clock; all state updates on its rising edge.
 RST  in  1  reset, asynchronous, active-high.
 IN_VALID  in  1  writeback request present.
 IN_READY  out  1  unit accepts a request this cycle.
 WB_SEL  in  2  source: 0 ALU, 1 MEM, 2 LINK, 3 none.
 RD_EN  in  1  request writes a register.
 RD_ADDR  in  ADDR_W  destination register.
 ALU_RESULT  in  DATA_W  execute-stage value.
 LINK_VALUE  in  DATA_W  return address (PC+4).
 LD_SIZE  in  2  0 byte, 1 half, 2 word, 3 treated as word.
 LD_SIGNED  in  1  sign-extend sub-word load.
 LD_OFFSET  in  OFF_W  byte offset within memory word.
 MEM_VALID  in  1  memory response present.
 MEM_DATA  in  DATA_W  memory response word.
 REG_WE  out  1  register-bank write strobe.
 REG_AA_ADDR  out  ADDR_W  write register index.
 REG_AA_DATA  out  DATA_W  write data.
 ERR  out  1  one-cycle pulse on memory timeout.

Function
REQ-006 States IDLE and WAIT_MEM; IN_READY SHALL be 1 exactly in IDLE.
REQ-007 Accept = IN_VALID & IN_READY; all request fields are sampled only on accept.
REQ-008 Accept with WB_SEL 0 or 2: REG_WE SHALL pulse the following cycle with ALU_RESULT or LINK_VALUE respectively; state stays IDLE, so back-to-back accepts yield back-to-back writes.
REQ-009 Accept with WB_SEL 3 or RD_EN=0 (and WB_SEL!=1): no write; state stays IDLE.
REQ-010 Accept with WB_SEL 1: latch RD_ADDR, RD_EN, LD_SIZE, LD_SIGNED, LD_OFFSET; enter WAIT_MEM; clear timeout counter.
REQ-011 MEM_VALID SHALL be ignored outside WAIT_MEM, including in the accept cycle.
REQ-012 In WAIT_MEM with MEM_VALID=1: extract the byte/half at LD_OFFSET (half uses offset with bit 0 ignored), zero- or sign-extend to DATA_W, pulse REG_WE next cycle (if latched RD_EN), return to IDLE.
REQ-013 In WAIT_MEM without MEM_VALID: increment counter; when counter reaches TIMEOUT, pulse ERR next cycle, discard the write, return to IDLE.
REQ-014 REG_WE SHALL be forced 0 when the write index is 0; REG_AA_ADDR/REG_AA_DATA still update.
REQ-015 REG_AA_ADDR and REG_AA_DATA SHALL be registered and hold their last value while REG_WE=0.
REQ-016 Write latency: 1 cycle after accept (ALU/LINK), 1 cycle after MEM_VALID (MEM).

Reset
REQ-017 RST=1 SHALL immediately force state IDLE, counter 0, REG_WE 0, ERR 0, REG_AA_ADDR 0, REG_AA_DATA 0.
REQ-018 Reset during WAIT_MEM SHALL abandon the load with no write and no ERR.

Structure
REQ-019 WB_SEL encodings, LD_SIZE encodings and state encoding SHALL live in shared package wb_pkg.
REQ-020 Load alignment/extension SHALL be one combinational sub-module, load_align.

Verification
REQ-021 ALU accept, ALU_RESULT=0x0000_1234, RD_ADDR=7 -> next cycle REG_WE=1, addr 7, data 0x0000_1234.
REQ-022 MEM byte, signed, offset 2, MEM_DATA=0x1280_FF00 after 3 cycles -> IN_READY low 3 cycles, then REG_WE=1, data 0x0000_0080 sign-extended to 0xFFFF_FF80.
REQ-023 MEM half, unsigned, offset 2, MEM_DATA=0xBEEF_0000 -> data 0x0000_BEEF.
REQ-024 MEM request, MEM_VALID never asserted, TIMEOUT=15 -> ERR pulse after 16 WAIT_MEM cycles, no REG_WE, IN_READY returns 1.
REQ-025 LINK accept with RD_ADDR=0, LINK_VALUE=0x0000_0040 -> REG_WE stays 0.
REQ-026 RST asserted mid-WAIT_MEM, MEM_VALID later -> no REG_WE, no ERR, outputs zero.
